jk_ff_bank: RTL

Parametrised bank of WIDTH JK flip-flops sharing one clock and one reset, with selectable per-edge update mode (JK, D, T, binary count). It replaces single-bit JK instances wherever a group of JK-style state bits, a toggle register or a small synchronous counter is needed. It adds features the single-bit flip-flop lacks: a clock enable, a defined reset value, change flags and a terminal-count indication.

---
 rtl/jk_ff_bank.sv | 93 +++++++++
 1 files changed

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK-style flip-flops with JK / D / T / binary-count update modes,
// clock enable, per-bit change flags and a terminal-count (next edge wraps) flag.

module jk_ff_cell #(
  parameter logic RST = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  input  logic       cnt_tgl,
  output logic       y,
  output logic       changed
);
  logic y_next;

  always_comb begin
    y_next = y;
    unique case (mode)
      2'b00: begin
        unique case ({j, k})
          2'b00: y_next = y;
          2'b01: y_next = 1'b0;
          2'b10: y_next = 1'b1;
          2'b11: y_next = ~y;
        endcase
      end
      2'b01: y_next = j;
      2'b10: y_next = y ^ j;
      2'b11: y_next = y ^ cnt_tgl;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y       <= RST;
      changed <= 1'b0;
    end else if (en) begin
      y       <= y_next;
      changed <= y ^ y_next;
    end else begin
      changed <= 1'b0;
    end
  end
endmodule

module jk_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_n,
  output logic [WIDTH-1:0] changed,
  output logic             tc
);
  logic [WIDTH-1:0] cnt_tgl;

  // Count toggle: bit i flips when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic run;
    run     = 1'b1;
    cnt_tgl = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_tgl[i] = run;
      run        = run & (k[0] ? ~y[i] : y[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_cell #(.RST(RESET_VAL[i])) u_cell (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
      .j       (j[i]),
      .k       (k[i]),
      .cnt_tgl (cnt_tgl[i]),
      .y       (y[i]),
      .changed (changed[i])
    );
  end

  assign y_n = ~y;
  assign tc  = (mode == 2'b11) & en & (k[0] ? (y == '0) : (&y));
endmodule
